// File: rtl/sr_ff_bank.sv
// Bank of N clocked SR flip-flops with compile-time S=R=1 resolution, sticky conflict flags
// and, when SR_BANK_CONFLICT_CNT_EN is defined, a saturating conflict-cycle counter.
module sr_ff_bank #(
  parameter int              N    = 8,
  parameter int              MODE = 0,
  parameter logic [N-1:0]    INIT = '0,
  parameter int              CW   = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [N-1:0]  s,
  input  logic [N-1:0]  r,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  input  logic          clr_flag,
  output logic [N-1:0]  q,
  output logic [N-1:0]  qbar,
  output logic [N-1:0]  conflict,
  output logic          any_conflict,
  output logic [CW-1:0] conflict_cnt
);

  if (MODE < 0 || MODE > 3) begin : g_bad_mode
    $error("sr_ff_bank: MODE must be 0..3");
  end
  if (N < 1 || N > 32) begin : g_bad_n
    $error("sr_ff_bank: N must be 1..32");
  end
  if (CW < 1 || CW > 16) begin : g_bad_cw
    $error("sr_ff_bank: CW must be 1..16");
  end

  logic [N-1:0] q_nxt;
  logic [N-1:0] hit;
  logic [N-1:0] conflict_nxt;

  // Conflicts are only observed while en=1; a disabled bank ignores s/r entirely.
  assign hit          = en ? (s & r) : '0;
  assign conflict_nxt = clr_flag ? hit : (conflict | hit);

  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = load_val;
    end else if (en) begin
      for (int i = 0; i < N; i++) begin
        case ({s[i], r[i]})
          2'b01:   q_nxt[i] = 1'b0;
          2'b10:   q_nxt[i] = 1'b1;
          2'b11: begin
            case (MODE)
              0:       q_nxt[i] = 1'b0;
              1:       q_nxt[i] = 1'b1;
              2:       q_nxt[i] = q[i];
              default: q_nxt[i] = ~q[i];
            endcase
          end
          default: q_nxt[i] = q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q            <= INIT;
      conflict     <= '0;
      any_conflict <= 1'b0;
    end else begin
      q            <= q_nxt;
      conflict     <= conflict_nxt;
      any_conflict <= |conflict_nxt;
    end
  end

  // Derived from the register itself, so it can never disagree with q.
  assign qbar = ~q;

`ifdef SR_BANK_CONFLICT_CNT_EN
  localparam logic [CW-1:0] CNT_MAX = '1;
  logic [CW-1:0] cnt_r;

  // A clear coinciding with a new conflict restarts the count at 1, not 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clr_flag) begin
      cnt_r <= CW'(|hit);
    end else if (|hit && cnt_r != CNT_MAX) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign conflict_cnt = cnt_r;
`else
  assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Bench for sr_ff_bank: one instance per conflict MODE (MODE 0 is the main checked instance)
// plus a CW=2 instance for counter saturation; expectations follow SR_BANK_CONFLICT_CNT_EN.
module tb_sr_ff_bank;

  localparam int W = 33;

  typedef struct {
    logic       rst, en, load, clr;
    logic [7:0] s, r, lv;
    logic [7:0] q, conf;
    logic       any;
    logic [7:0] cnt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst, en, load, clr_flag;
  logic [7:0] s, r, load_val;

  logic [7:0] q_m [4];
  logic [7:0] qbar_m [4];
  logic [7:0] conf_m [4];
  logic       any_m [4];
  logic [7:0] cnt_m [4];

  logic [7:0] sat_q, sat_qbar, sat_conf;
  logic       sat_any;
  logic [1:0] sat_cnt;

  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_mode
    sr_ff_bank #(.N(8), .MODE(g), .INIT(8'hA5), .CW(8)) u_dut (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .load(load), .load_val(load_val),
      .clr_flag(clr_flag), .q(q_m[g]), .qbar(qbar_m[g]), .conflict(conf_m[g]),
      .any_conflict(any_m[g]), .conflict_cnt(cnt_m[g])
    );
  end

  sr_ff_bank #(.N(8), .MODE(0), .INIT(8'hA5), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .load(load), .load_val(load_val),
    .clr_flag(clr_flag), .q(sat_q), .qbar(sat_qbar), .conflict(sat_conf),
    .any_conflict(sat_any), .conflict_cnt(sat_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rs, input logic e, input logic ld, input logic c,
                              input logic [7:0] sv, input logic [7:0] rv, input logic [7:0] lv,
                              input logic [7:0] eq, input logic [7:0] ec, input logic ea,
                              input logic [7:0] en_cnt);
    vec_t v;
    v.rst = rs; v.en = e; v.load = ld; v.clr = c;
    v.s = sv; v.r = rv; v.lv = lv;
    v.q = eq; v.conf = ec; v.any = ea; v.cnt = en_cnt;
    return v;
  endfunction

  // Drive on a falling edge, let one rising edge pass, compare on the next falling edge.
  task automatic step(input vec_t v, input string tag);
    logic [W-1:0] e;
    logic [7:0]   ecnt;
    rst = v.rst; en = v.en; load = v.load; clr_flag = v.clr;
    s = v.s; r = v.r; load_val = v.lv;
`ifdef SR_BANK_CONFLICT_CNT_EN
    ecnt = v.cnt;
`else
    ecnt = 8'h00;
`endif
    exp_q.push_back({v.q, ~v.q, v.conf, v.any, ecnt});
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: got empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_q"},    {24'h0, q_m[0]},    {24'h0, e[32:25]});
      chk({tag, "_qbar"}, {24'h0, qbar_m[0]}, {24'h0, e[24:17]});
      chk({tag, "_conf"}, {24'h0, conf_m[0]}, {24'h0, e[16:9]});
      chk({tag, "_any"},  {31'h0, any_m[0]},  {31'h0, e[8]});
      chk({tag, "_cnt"},  {24'h0, cnt_m[0]},  {24'h0, e[7:0]});
    end
  endtask

  vec_t tbl [16];
  logic [2:0] mexp [4];
  logic [1:0] sexp [5];

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; clr_flag = 1'b0;
    s = '0; r = '0; load_val = '0;

    //          rst en ld clr  s      r      lv     q      conf   any cnt
    tbl[0]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 8'd0);
    tbl[1]  = mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 8'd0);
    tbl[2]  = mk(0, 1, 0, 0, 8'h01, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 8'd0);
    tbl[3]  = mk(0, 1, 0, 0, 8'h00, 8'h01, 8'h00, 8'hA4, 8'h00, 0, 8'd0);
    tbl[4]  = mk(0, 1, 0, 0, 8'hF0, 8'h0F, 8'h00, 8'hF0, 8'h00, 0, 8'd0);
    tbl[5]  = mk(0, 0, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'hF0, 8'h00, 0, 8'd0);
    tbl[6]  = mk(0, 1, 1, 0, 8'hFF, 8'h00, 8'h3C, 8'h3C, 8'h00, 0, 8'd0);
    tbl[7]  = mk(0, 1, 0, 0, 8'h04, 8'h04, 8'h00, 8'h38, 8'h04, 1, 8'd1);
    tbl[8]  = mk(0, 1, 0, 1, 8'h04, 8'h04, 8'h00, 8'h38, 8'h04, 1, 8'd1);
    tbl[9]  = mk(0, 1, 0, 1, 8'h00, 8'h00, 8'h00, 8'h38, 8'h00, 0, 8'd0);
    tbl[10] = mk(0, 1, 0, 0, 8'h03, 8'h03, 8'h00, 8'h38, 8'h03, 1, 8'd1);
    tbl[11] = mk(0, 1, 0, 0, 8'h80, 8'h00, 8'h00, 8'hB8, 8'h03, 1, 8'd1);
    tbl[12] = mk(0, 1, 1, 0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h03, 1, 8'd2);
    tbl[13] = mk(1, 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 8'hA5, 8'h00, 0, 8'd0);
    tbl[14] = mk(0, 1, 0, 0, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, 1, 8'd1);
    tbl[15] = mk(0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 8'd1);

    mexp[0] = 3'b000; mexp[1] = 3'b111; mexp[2] = 3'b000; mexp[3] = 3'b101;
`ifdef SR_BANK_CONFLICT_CNT_EN
    sexp[0] = 2'd1; sexp[1] = 2'd2; sexp[2] = 2'd3; sexp[3] = 2'd3; sexp[4] = 2'd3;
`else
    for (int k = 0; k < 5; k++) sexp[k] = 2'd0;
`endif

    @(negedge clk);
    for (int i = 0; i < 16; i++) step(tbl[i], $sformatf("vec%0d", i));

    // Disabled bank: random s/r must neither move q nor raise flags.
    for (int i = 0; i < 6; i++) begin
      step(mk(0, 0, 0, 0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00,
              8'h00, 8'hFF, 1, 8'd1), $sformatf("hold%0d", i));
    end

    // Conflict resolution per MODE on channel 0 starting from q=0, and CW=2 saturation.
    step(mk(1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 8'd0), "mrst");
    chk("sat_rst_cnt", {30'h0, sat_cnt}, 32'h0);
    step(mk(0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'd0), "mload");
    for (int j = 0; j < 5; j++) begin
      step(mk(0, 1, 0, 0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 1, 8'(j + 1)),
           $sformatf("mconf%0d", j));
      if (j < 3) begin
        for (int k = 1; k < 4; k++) begin
          chk($sformatf("mode%0d_q0_e%0d", k, j), {31'h0, q_m[k][0]}, {31'h0, mexp[k][2-j]});
          chk($sformatf("mode%0d_conf0_e%0d", k, j), {31'h0, conf_m[k][0]}, 32'h1);
          chk($sformatf("mode%0d_any_e%0d", k, j), {31'h0, any_m[k]}, 32'h1);
        end
      end
      chk($sformatf("sat_cnt_e%0d", j), {30'h0, sat_cnt}, {30'h0, sexp[j]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
